// File: rtl/tl_pkg.sv
// Shared types and constants for the completion TX packer.
package tl_pkg;

    localparam int TL_BEAT_DW      = 4;
    localparam int TL_CPL_HDR_DW   = 3;
    localparam int TL_FMT_DATA_BIT = 126;
    // Width used for all DW/beat arithmetic; wide enough for 3 + max payload.
    localparam int TL_TOT_W        = 8;

    typedef struct packed {
        logic [127:0] data;
        logic         sop;
        logic         eop;
        logic [3:0]   dw_en;
    } tl_beat_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_SEND      = 2'd2
    } tl_state_e;

    // Number of 4-DW beats needed to carry total_dw DWs (rounded up).
    function automatic logic [TL_TOT_W-1:0] tl_dw_to_beats(input logic [TL_TOT_W-1:0] total_dw);
        tl_dw_to_beats = (total_dw + TL_TOT_W'(TL_BEAT_DW - 1)) / TL_TOT_W'(TL_BEAT_DW);
    endfunction

endpackage

// File: rtl/tl_cpl_tx_packer_if.sv
// Completion input and TLP output handshake bundle for the TX packer.
interface tl_cpl_tx_packer_if #(
    parameter int MAX_PAYLOAD_DW = 8,
    parameter int CNT_W          = 16
);
    logic [127:0]                cpl_hdr_i;
    logic                        cpl_hdr_valid_i;
    logic                        cpl_hdr_ready_o;
    logic [32*MAX_PAYLOAD_DW-1:0] cpl_data_i;
    logic                        cpl_data_valid_i;
    logic                        cpl_data_ready_o;
    logic [127:0]                tx_data_o;
    logic                        tx_valid_o;
    logic                        tx_ready_i;
    logic                        tx_sop_o;
    logic                        tx_eop_o;
    logic [3:0]                  tx_dw_en_o;
    logic                        len_err_o;
    logic [CNT_W-1:0]            tlp_cnt_o;

    // Producer / consumer side that talks to the packer.
    modport master (
        output cpl_hdr_i, cpl_hdr_valid_i, cpl_data_i, cpl_data_valid_i, tx_ready_i,
        input  cpl_hdr_ready_o, cpl_data_ready_o, tx_data_o, tx_valid_o, tx_sop_o,
               tx_eop_o, tx_dw_en_o, len_err_o, tlp_cnt_o
    );

    // The packer itself.
    modport slave (
        input  cpl_hdr_i, cpl_hdr_valid_i, cpl_data_i, cpl_data_valid_i, tx_ready_i,
        output cpl_hdr_ready_o, cpl_data_ready_o, tx_data_o, tx_valid_o, tx_sop_o,
               tx_eop_o, tx_dw_en_o, len_err_o, tlp_cnt_o
    );
endinterface

// File: rtl/tl_beat_mux.sv
// Combinational selector: builds one 4-lane beat of a completion TLP
// from the stored header DWs and payload DWs.
module tl_beat_mux
    import tl_pkg::*;
#(
    parameter int MAX_PAYLOAD_DW = 8
) (
    input  logic [32*TL_CPL_HDR_DW-1:0]  hdr,       // DW0 in the top 32 bits
    input  logic [32*MAX_PAYLOAD_DW-1:0] data,      // data DWk at [32k+31:32k]
    input  logic [TL_TOT_W-1:0]          total,     // TLP length in DW
    input  logic [1:0]                   beat_idx,
    output tl_beat_t                     beat
);
    localparam int NDW = TL_CPL_HDR_DW + MAX_PAYLOAD_DW;

    logic [32*NDW-1:0]   flat_s;   // TLP DW i at [32i+31:32i]
    logic [TL_TOT_W-1:0] beats_s;

    assign flat_s  = {data, hdr[31:0], hdr[63:32], hdr[95:64]};
    assign beats_s = tl_dw_to_beats(total);

    // Place TLP DW 4*beat_idx+j on lane j; lanes past the TLP end are zero and disabled.
    always_comb begin
        beat = '0;
        for (int j = 0; j < TL_BEAT_DW; j++) begin
            if ((TL_BEAT_DW * int'(beat_idx) + j) < int'(total)) begin
                beat.data[127-32*j -: 32] = 32'(flat_s >> (32 * (TL_BEAT_DW * int'(beat_idx) + j)));
                beat.dw_en[3-j]           = 1'b1;
            end else begin
                beat.data[127-32*j -: 32] = 32'd0;
                beat.dw_en[3-j]           = 1'b0;
            end
        end
        beat.sop = (beat_idx == 2'd0);
        beat.eop = (TL_TOT_W'(beat_idx) == (beats_s - TL_TOT_W'(1)));
    end
endmodule

// File: rtl/tl_cpl_tx_packer.sv
// Completion TX packer: captures one Cpl/CplD header plus payload and
// streams it as 128-bit beats with SOP/EOP/DW enables under backpressure.
module tl_cpl_tx_packer
    import tl_pkg::*;
#(
    parameter int MAX_PAYLOAD_DW = 8,
    parameter int CNT_W          = 16
) (
    input logic               clk,
    input logic               rst_n,
    tl_cpl_tx_packer_if.slave bus
);
    tl_state_e                   state_r, state_s;
    logic [32*TL_CPL_HDR_DW-1:0] hdr_r;
    logic [TL_TOT_W-1:0]         total_r, hdr_total_s;
    logic                        has_data_r;
    logic [32*MAX_PAYLOAD_DW-1:0] data_buf_r;
    logic                        data_buf_vld_r;
    logic                        len_err_r;
    logic [CNT_W-1:0]            tlp_cnt_r;
    logic [1:0]                  beat_idx_r;
    tl_beat_t                    beat_r, mux_beat_s;
    logic                        tx_valid_r;
    logic                        hdr_fire_s, data_fire_s, eop_acc_s, load_s;
    logic                        hdr_has_data_s, len_bad_s;
    logic [9:0]                  hdr_len_s;
    logic                        unused_hdr_s;

    // Header DW3 slot carries nothing for completions.
    assign unused_hdr_s = ^bus.cpl_hdr_i[31:0];

    // Handshake decode and length legality of the header on the bus.
    always_comb begin
        hdr_fire_s     = bus.cpl_hdr_valid_i & (state_r == ST_IDLE);
        data_fire_s    = bus.cpl_data_valid_i & ~data_buf_vld_r;
        eop_acc_s      = (state_r == ST_SEND) & tx_valid_r & beat_r.eop & bus.tx_ready_i;
        load_s         = (state_r == ST_SEND) & (~tx_valid_r | (bus.tx_ready_i & ~beat_r.eop));
        hdr_has_data_s = bus.cpl_hdr_i[TL_FMT_DATA_BIT];
        hdr_len_s      = bus.cpl_hdr_i[105:96];
        len_bad_s      = hdr_has_data_s &
                         ((hdr_len_s == 10'd0) | (hdr_len_s > 10'(MAX_PAYLOAD_DW)));
        if (!hdr_has_data_s) begin
            hdr_total_s = TL_TOT_W'(TL_CPL_HDR_DW);
        end else if (len_bad_s) begin
            hdr_total_s = TL_TOT_W'(TL_CPL_HDR_DW + MAX_PAYLOAD_DW);
        end else begin
            hdr_total_s = TL_TOT_W'(TL_CPL_HDR_DW) + TL_TOT_W'(hdr_len_s);
        end
    end

    // Next-state logic: wait for payload only when a CplD has none buffered.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hdr_fire_s) begin
                    if (!hdr_has_data_s || data_buf_vld_r || data_fire_s) begin
                        state_s = ST_SEND;
                    end else begin
                        state_s = ST_WAIT_DATA;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_DATA: begin
                if (data_fire_s) begin
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_WAIT_DATA;
                end
            end
            ST_SEND: begin
                if (eop_acc_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SEND;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Header capture and one-cycle illegal-length pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_r      <= '0;
            has_data_r <= 1'b0;
            total_r    <= '0;
            len_err_r  <= 1'b0;
        end else begin
            len_err_r <= hdr_fire_s & len_bad_s;
            if (hdr_fire_s) begin
                hdr_r      <= bus.cpl_hdr_i[127:32];
                has_data_r <= hdr_has_data_s;
                total_r    <= hdr_total_s;
            end
        end
    end

    // Payload buffer, filled independently of the header; freed when its TLP ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_buf_r     <= '0;
            data_buf_vld_r <= 1'b0;
        end else if (data_fire_s) begin
            data_buf_r     <= bus.cpl_data_i;
            data_buf_vld_r <= 1'b1;
        end else if (eop_acc_s && has_data_r) begin
            data_buf_vld_r <= 1'b0;
        end
    end

    tl_beat_mux #(
        .MAX_PAYLOAD_DW(MAX_PAYLOAD_DW)
    ) u_beat_mux (
        .hdr      (hdr_r),
        .data     (data_buf_r),
        .total    (total_r),
        .beat_idx (beat_idx_r),
        .beat     (mux_beat_s)
    );

    // Output beat register: load next beat when empty or on non-final accept, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_r     <= '0;
            tx_valid_r <= 1'b0;
            beat_idx_r <= 2'd0;
        end else if (load_s) begin
            beat_r     <= mux_beat_s;
            tx_valid_r <= 1'b1;
            beat_idx_r <= beat_idx_r + 2'd1;
        end else if (eop_acc_s) begin
            beat_r     <= '0;
            tx_valid_r <= 1'b0;
            beat_idx_r <= 2'd0;
        end
    end

    // Count of fully transmitted TLPs, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         tlp_cnt_r <= '0;
        else if (eop_acc_s) tlp_cnt_r <= tlp_cnt_r + CNT_W'(1);
    end

    assign bus.cpl_hdr_ready_o  = (state_r == ST_IDLE);
    assign bus.cpl_data_ready_o = ~data_buf_vld_r;
    assign bus.tx_data_o        = beat_r.data;
    assign bus.tx_valid_o       = tx_valid_r;
    assign bus.tx_sop_o         = beat_r.sop;
    assign bus.tx_eop_o         = beat_r.eop;
    assign bus.tx_dw_en_o       = beat_r.dw_en;
    assign bus.len_err_o        = len_err_r;
    assign bus.tlp_cnt_o        = tlp_cnt_r;
endmodule

// File: tb/tb_tl_cpl_tx_packer.sv
// Directed bench for tl_cpl_tx_packer with a queue-based TLP model.
module tb_tl_cpl_tx_packer;
    localparam int MAXP = 8;

    typedef struct packed {
        logic [127:0] data;
        logic         sop;
        logic         eop;
        logic [3:0]   en;
    } exp_beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    tl_cpl_tx_packer_if #(.MAX_PAYLOAD_DW(MAXP), .CNT_W(16)) bus ();

    tl_cpl_tx_packer #(.MAX_PAYLOAD_DW(MAXP), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int        n_checks = 0;
    int        n_pass   = 0;
    exp_beat_t exp_q[$];
    logic [15:0] model_cnt = 16'd0;
    logic      in_tlp    = 1'b0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    // Expected beats of one TLP, from the packing rules.
    function automatic void push_tlp(input logic [127:0] hdr, input logic [255:0] data);
        logic [31:0] dw[$];
        int total, leff, l, nb, idx;
        exp_beat_t b;
        dw.push_back(hdr[127:96]);
        dw.push_back(hdr[95:64]);
        dw.push_back(hdr[63:32]);
        for (int k = 0; k < MAXP; k++) dw.push_back(data[32*k +: 32]);
        if (hdr[126]) begin
            l     = int'(hdr[105:96]);
            leff  = (l == 0 || l > MAXP) ? MAXP : l;
            total = 3 + leff;
        end else begin
            total = 3;
        end
        nb = (total + 3) / 4;
        for (int bi = 0; bi < nb; bi++) begin
            b = '0;
            for (int j = 0; j < 4; j++) begin
                idx = 4 * bi + j;
                if (idx < total) begin
                    b.data[127-32*j -: 32] = dw[idx];
                    b.en[3-j] = 1'b1;
                end
            end
            b.sop = (bi == 0);
            b.eop = (bi == nb - 1);
            exp_q.push_back(b);
        end
    endfunction

    // Per-cycle compare against the model; acceptance is decided before the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("tlp_cnt", 128'(bus.tlp_cnt_o), 128'(model_cnt));
            if (bus.tx_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 128'(bus.tx_valid_o), 128'(0));
                end else begin
                    chk("beat_data", bus.tx_data_o, exp_q[0].data);
                    chk("beat_sop", 128'(bus.tx_sop_o), 128'(exp_q[0].sop));
                    chk("beat_eop", 128'(bus.tx_eop_o), 128'(exp_q[0].eop));
                    chk("beat_en", 128'(bus.tx_dw_en_o), 128'(exp_q[0].en));
                    if (bus.tx_ready_i) begin
                        if (exp_q[0].eop) model_cnt = model_cnt + 16'd1;
                        in_tlp = !exp_q[0].eop;
                        exp_q.delete(0);
                    end
                end
            end else if (in_tlp) begin
                chk("no_bubble", 128'(bus.tx_valid_o), 128'(1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (bus.cpl_hdr_ready_o && exp_q.size() == 0 && !bus.tx_valid_o) done = 1'b1;
            else tick();
        end
        chk(name, 128'(done), 128'(1));
    endtask

    task automatic wait_beat1(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus.tx_valid_o && !bus.tx_sop_o) done = 1'b1;
            else tick();
        end
        chk(name, 128'(done), 128'(1));
    endtask

    localparam logic [127:0] H_CPL  = {32'h0A00_0000, 32'h0100_2004, 32'h0000_1500, 32'hFFFF_FFFF};
    localparam logic [127:0] H_D1   = {32'h4A00_0001, 32'h0100_0004, 32'h0000_2A00, 32'h0000_0000};
    localparam logic [127:0] H_D8   = {32'h4A00_0008, 32'h0100_0020, 32'h0000_3300, 32'h0000_0000};
    localparam logic [127:0] H_L0   = {32'h4A00_0000, 32'h0100_0020, 32'h0000_4400, 32'h0000_0000};
    localparam logic [127:0] H_L9   = {32'h4A00_0009, 32'h0100_0024, 32'h0000_4500, 32'h0000_0000};

    initial begin
        logic [255:0] d8;
        logic [255:0] d1;
        exp_beat_t    snap;
        int           nticks;

        for (int k = 0; k < MAXP; k++) d8[32*k +: 32] = 32'hA000_0000 + 32'(k);
        d1 = 256'h0;
        d1[31:0] = 32'hDEAD_BEEF;
        bus.cpl_hdr_i        = 128'h0;
        bus.cpl_hdr_valid_i  = 1'b0;
        bus.cpl_data_i       = 256'h0;
        bus.cpl_data_valid_i = 1'b0;
        bus.tx_ready_i       = 1'b1;

        // Reset state
        #2;
        chk("rst_hdr_ready", 128'(bus.cpl_hdr_ready_o), 128'(1));
        chk("rst_data_ready", 128'(bus.cpl_data_ready_o), 128'(1));
        chk("rst_outs", {bus.tx_data_o}, 128'h0);
        chk("rst_flags", 128'({bus.tx_valid_o, bus.tx_sop_o, bus.tx_eop_o, bus.tx_dw_en_o,
                               bus.len_err_o, bus.tlp_cnt_o}), 128'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // 1: Cpl without data
        push_tlp(H_CPL, 256'h0);
        bus.cpl_hdr_i = H_CPL; bus.cpl_hdr_valid_i = 1'b1;
        tick();
        bus.cpl_hdr_valid_i = 1'b0;
        chk("cpl_lat0", 128'(bus.tx_valid_o), 128'(0));
        chk("cpl_hdr_busy", 128'(bus.cpl_hdr_ready_o), 128'(0));
        tick();
        chk("cpl_valid", 128'(bus.tx_valid_o), 128'(1));
        chk("cpl_data", bus.tx_data_o, {32'h0A00_0000, 32'h0100_2004, 32'h0000_1500, 32'h0});
        chk("cpl_en", 128'({bus.tx_sop_o, bus.tx_eop_o, bus.tx_dw_en_o}), 128'(6'b11_1110));
        tick();
        chk("cpl_cnt", 128'(bus.tlp_cnt_o), 128'(1));
        chk("cpl_hdr_ready", 128'(bus.cpl_hdr_ready_o), 128'(1));

        // 2: CplD L=1, header and data together
        push_tlp(H_D1, d1);
        bus.cpl_hdr_i = H_D1; bus.cpl_hdr_valid_i = 1'b1;
        bus.cpl_data_i = d1;  bus.cpl_data_valid_i = 1'b1;
        tick();
        bus.cpl_hdr_valid_i = 1'b0; bus.cpl_data_valid_i = 1'b0;
        chk("d1_data_busy", 128'(bus.cpl_data_ready_o), 128'(0));
        chk("d1_no_lenerr", 128'(bus.len_err_o), 128'(0));
        tick();
        chk("d1_valid", 128'(bus.tx_valid_o), 128'(1));
        chk("d1_lane3", 128'(bus.tx_data_o[31:0]), 128'(32'hDEAD_BEEF));
        chk("d1_en", 128'({bus.tx_sop_o, bus.tx_eop_o, bus.tx_dw_en_o}), 128'(6'b11_1111));
        wait_idle("d1_idle");
        chk("d1_data_ready", 128'(bus.cpl_data_ready_o), 128'(1));

        // 3: CplD L=8, data 3 cycles after header
        push_tlp(H_D8, d8);
        bus.cpl_hdr_i = H_D8; bus.cpl_hdr_valid_i = 1'b1;
        tick();
        bus.cpl_hdr_valid_i = 1'b0;
        tick();
        chk("d8_wait", 128'(bus.cpl_hdr_ready_o | bus.tx_valid_o), 128'(0));
        tick();
        bus.cpl_data_i = d8; bus.cpl_data_valid_i = 1'b1;
        tick();
        bus.cpl_data_valid_i = 1'b0;
        chk("d8_lat0", 128'(bus.tx_valid_o), 128'(0));
        tick();
        chk("d8_sop", 128'({bus.tx_valid_o, bus.tx_sop_o}), 128'(2'b11));
        nticks = 0;
        while (!(bus.tx_valid_o && bus.tx_eop_o) && nticks < 10) begin
            tick();
            nticks++;
        end
        chk("d8_beats", 128'(nticks), 128'(2));
        chk("d8_b2_lanes", 128'(bus.tx_data_o[127:32]), 128'(96'hA000_0005_A000_0006_A000_0007));
        chk("d8_b2_en", 128'(bus.tx_dw_en_o), 128'(4'b1110));
        wait_idle("d8_idle");

        // 4: same with backpressure on beat1
        push_tlp(H_D8, d8);
        bus.cpl_hdr_i = H_D8; bus.cpl_hdr_valid_i = 1'b1;
        tick();
        bus.cpl_hdr_valid_i = 1'b0;
        tick(); tick();
        bus.cpl_data_valid_i = 1'b1;
        tick();
        bus.cpl_data_valid_i = 1'b0;
        wait_beat1("bp_beat1_seen");
        bus.tx_ready_i = 1'b0;
        snap = {bus.tx_data_o, bus.tx_sop_o, bus.tx_eop_o, bus.tx_dw_en_o};
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("bp_hold", {bus.tx_data_o}, snap.data);
            chk("bp_hold_ctl", 128'({bus.tx_valid_o, bus.tx_sop_o, bus.tx_eop_o, bus.tx_dw_en_o}),
                128'({1'b1, snap.sop, snap.eop, snap.en}));
        end
        bus.tx_ready_i = 1'b1;
        tick();
        chk("bp_beat2", 128'({bus.tx_valid_o, bus.tx_sop_o, bus.tx_eop_o}), 128'(3'b101));
        wait_idle("bp_idle");

        // 5: illegal lengths 0 and 9
        push_tlp(H_L0, d8);
        bus.cpl_hdr_i = H_L0; bus.cpl_hdr_valid_i = 1'b1;
        bus.cpl_data_i = d8;  bus.cpl_data_valid_i = 1'b1;
        tick();
        bus.cpl_hdr_valid_i = 1'b0; bus.cpl_data_valid_i = 1'b0;
        chk("l0_err", 128'(bus.len_err_o), 128'(1));
        tick();
        chk("l0_err_pulse", 128'(bus.len_err_o), 128'(0));
        wait_idle("l0_idle");
        push_tlp(H_L9, d8);
        bus.cpl_hdr_i = H_L9; bus.cpl_hdr_valid_i = 1'b1;
        bus.cpl_data_valid_i = 1'b1;
        tick();
        bus.cpl_hdr_valid_i = 1'b0; bus.cpl_data_valid_i = 1'b0;
        chk("l9_err", 128'(bus.len_err_o), 128'(1));
        tick();
        chk("l9_err_pulse", 128'(bus.len_err_o), 128'(0));
        wait_idle("l9_idle");
        chk("cnt_six", 128'(bus.tlp_cnt_o), 128'(6));

        // 6: reset mid-SEND
        push_tlp(H_D8, d8);
        bus.cpl_hdr_i = H_D8; bus.cpl_hdr_valid_i = 1'b1;
        bus.cpl_data_valid_i = 1'b1;
        tick();
        bus.cpl_hdr_valid_i = 1'b0; bus.cpl_data_valid_i = 1'b0;
        wait_beat1("rst_beat1_seen");
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        in_tlp = 1'b0;
        model_cnt = 16'd0;
        #1;
        chk("rst_mid_valid", 128'({bus.tx_valid_o, bus.tx_sop_o, bus.tx_eop_o, bus.tx_dw_en_o}), 128'(0));
        chk("rst_mid_data", bus.tx_data_o, 128'h0);
        chk("rst_mid_cnt", 128'(bus.tlp_cnt_o), 128'(0));
        chk("rst_mid_ready", 128'({bus.cpl_hdr_ready_o, bus.cpl_data_ready_o}), 128'(2'b11));
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        push_tlp(H_CPL, 256'h0);
        bus.cpl_hdr_i = H_CPL; bus.cpl_hdr_valid_i = 1'b1;
        tick();
        bus.cpl_hdr_valid_i = 1'b0;
        tick();
        chk("post_rst_sop", 128'({bus.tx_valid_o, bus.tx_sop_o}), 128'(2'b11));
        wait_idle("post_rst_idle");
        chk("post_rst_cnt", 128'(bus.tlp_cnt_o), 128'(1));
        chk("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
